// File: rtl/pc_ras_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras_unit_pkg
// Description : Shared types and constants for the fetch PC / return-address
//               stack unit.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_ras_unit_pkg;

    localparam int WORD_W_DEF    = 32;
    localparam int RAS_DEPTH_DEF = 8;

    typedef logic [WORD_W_DEF-1:0]              word_t;
    typedef logic [$clog2(RAS_DEPTH_DEF)-1:0]   ras_ptr_t;

    localparam word_t PC_INC_DEF = 32'd4;

    // Next-PC source, ordered from lowest to highest priority
    typedef enum logic [1:0] {
        NPC_HOLD  = 2'd0,
        NPC_SEQ   = 2'd1,
        NPC_RET   = 2'd2,
        NPC_REDIR = 2'd3
    } npc_sel_e;

    // Word-aligned targets have both low address bits clear
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_ras_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras_if
// Description : Signal bundle for pc_ras_unit with a unit-side (pc) view and
//               a stimulus/observer (tb) view.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_ras_if #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 4
) (
    input logic clk
);
    logic              rst;
    logic              ihit;
    logic              stall;
    logic              redirect_en;
    logic [WORD_W-1:0] redirect_pc;
    logic              push_en;
    logic [WORD_W-1:0] push_addr;
    logic              ret_en;
    logic [WORD_W-1:0] fetch_pc;
    logic [WORD_W-1:0] pc4;
    logic [WORD_W-1:0] ras_top;
    logic [CNT_W-1:0]  ras_count;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_ovf;
    logic              misalign;

    modport pc (
        input  clk, rst, ihit, stall, redirect_en, redirect_pc,
               push_en, push_addr, ret_en,
        output fetch_pc, pc4, ras_top, ras_count, ras_empty, ras_full,
               ras_ovf, misalign
    );

    modport tb (
        input  clk, fetch_pc, pc4, ras_top, ras_count, ras_empty, ras_full,
               ras_ovf, misalign,
        output rst, ihit, stall, redirect_en, redirect_pc,
               push_en, push_addr, ret_en
    );
endinterface
`default_nettype wire

// File: rtl/pc_ras_unit_ras_stack.sv
`default_nettype none
// ============================================================================
// Module      : ras_stack
// Description : Circular return-address stack. Push writes top+1, pop moves
//               top down, push+pop replaces the top entry. A push while full
//               overwrites the oldest entry and sets the sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ras_stack #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WORD_W-1:0]          din_i,
    output logic [WORD_W-1:0]          top_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       ovf_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  top_q, top_d;
    logic [PTR_W-1:0]  wr_ptr;
    logic              wr_en;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              nonempty;

    assign nonempty = (cnt_q != '0);

    // Pointer, count and overflow next-state for push / pop / replace
    always_comb begin
        top_d  = top_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        wr_en  = 1'b0;
        wr_ptr = top_q;
        if (push_i && pop_i && nonempty) begin
            // Return consumed and call made together: swap the top entry
            wr_en  = 1'b1;
            wr_ptr = top_q;
        end else if (push_i) begin
            wr_en  = 1'b1;
            wr_ptr = top_q + 1'b1;
            top_d  = top_q + 1'b1;
            if (cnt_q == CNT_FULL) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (pop_i && nonempty) begin
            top_d = top_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Control state; reset discards the stack without touching storage
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            top_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Entry storage, intentionally not reset
    always_ff @(posedge clk_i) begin
        if (wr_en && !rst_i) begin
            mem_q[wr_ptr] <= din_i;
        end
    end

    assign top_o   = mem_q[top_q];
    assign count_o = cnt_q;
    assign full_o  = (cnt_q == CNT_FULL);
    assign empty_o = ~nonempty;
    assign ovf_o   = ovf_q;

endmodule
`default_nettype wire

// File: rtl/pc_ras_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras_unit
// Description : Fetch program counter with next-PC selection (reset,
//               redirect, predicted return, sequential, hold) and an
//               integrated return-address stack.
//               Optional feature macro PCU_MISALIGN_EN: misaligned redirects
//               go to TRAP_VEC and pulse misalign.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ras_unit
    import pc_ras_unit_pkg::*;
#(
    parameter int                WORD_W    = 32,
    parameter logic [WORD_W-1:0] PC_INIT   = '0,
    parameter logic [WORD_W-1:0] PC_INC    = WORD_W'(PC_INC_DEF),
    parameter int                RAS_DEPTH = RAS_DEPTH_DEF,
    parameter logic [WORD_W-1:0] TRAP_VEC  = WORD_W'(32'h0000_0080)
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         ihit,
    input  logic                         stall,
    input  logic                         redirect_en,
    input  logic [WORD_W-1:0]            redirect_pc,
    input  logic                         push_en,
    input  logic [WORD_W-1:0]            push_addr,
    input  logic                         ret_en,
    output logic [WORD_W-1:0]            PC,
    output logic [WORD_W-1:0]            PC4,
    output logic [WORD_W-1:0]            ras_top,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_empty,
    output logic                         ras_full,
    output logic                         ras_ovf,
    output logic                         misalign
);

    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] redir_tgt;
    logic              advance;
    logic              ret_take;
    logic              do_pop;
    logic              do_push;
    npc_sel_e          npc_sel;

    assign advance  = ihit & ~stall;
    assign ret_take = advance & ret_en & ~ras_empty;
    // A resolved redirect squashes the predicted return, so no pop
    assign do_pop   = ret_take & ~redirect_en;
    assign do_push  = push_en & ~stall;

`ifdef PCU_MISALIGN_EN
    logic misalign_q;

    assign redir_tgt = is_misaligned(redirect_pc[1:0]) ? TRAP_VEC : redirect_pc;

    // One-cycle flag for the edge that took a misaligned redirect
    always_ff @(posedge CLK) begin
        if (RST) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect_en & is_misaligned(redirect_pc[1:0]);
        end
    end

    assign misalign = misalign_q;
`else
    logic unused_trap_vec;

    assign redir_tgt       = redirect_pc;
    assign misalign        = 1'b0;
    assign unused_trap_vec = ^TRAP_VEC;
`endif

    // Next-PC source selection, highest priority last-tested first
    always_comb begin
        npc_sel = NPC_HOLD;
        if (redirect_en) begin
            npc_sel = NPC_REDIR;
        end else if (ret_take) begin
            npc_sel = NPC_RET;
        end else if (advance) begin
            npc_sel = NPC_SEQ;
        end
    end

    // Next-PC data mux
    always_comb begin
        pc_d = pc_q;
        case (npc_sel)
            NPC_REDIR: pc_d = redir_tgt;
            NPC_RET:   pc_d = ras_top;
            NPC_SEQ:   pc_d = PC4;
            default:   pc_d = pc_q;
        endcase
    end

    // Fetch PC register
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q <= PC_INIT;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PC  = pc_q;
    assign PC4 = pc_q + PC_INC;

    ras_stack #(
        .WORD_W (WORD_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (do_push),
        .pop_i   (do_pop),
        .din_i   (push_addr),
        .top_o   (ras_top),
        .count_o (ras_count),
        .full_o  (ras_full),
        .empty_o (ras_empty),
        .ovf_o   (ras_ovf)
    );

endmodule
`default_nettype wire
